// File: rtl/phase_pkg.sv
// phase_pkg: shared types and helpers for the phase-bus monitor
package phase_pkg;

    localparam int NPHASE_DEF = 5;

    typedef logic [$clog2(NPHASE_DEF)-1:0] phase_idx_t;

    typedef enum logic {
        HUNT,
        LOCKED
    } phase_mon_state_t;

    typedef enum logic [1:0] {
        PH_ZERO,
        PH_ONE,
        PH_MULTI
    } phase_class_t;

    // Index width that stays legal for a single-phase bus
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_onehot_dec.sv
// phase_onehot_dec: classify a phase-enable sample as zero, one-hot (with index) or multi-hot
module phase_onehot_dec
    import phase_pkg::*;
#(
    parameter int NPHASE = NPHASE_DEF,
    parameter int IW     = idx_width(NPHASE)
) (
    input  logic [NPHASE-1:0] phase_en_i,
    output phase_class_t      cls_o,
    output logic [IW-1:0]     idx_o
);

    logic seen;
    logic multi;

    // Scan all enables; a second hot bit marks the sample as multi-hot
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx_o = '0;
        for (int i = 0; i < NPHASE; i++) begin
            if (phase_en_i[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
                idx_o = IW'(i);
            end
        end
        cls_o = multi ? PH_MULTI : (seen ? PH_ONE : PH_ZERO);
    end

endmodule

// File: rtl/phase_monitor.sv
// phase_monitor: recover phase index from the phase-enable bus and flag protocol errors
// Optional completed-cycle counter enabled by defining PHASE_MON_CNT_EN.
module phase_monitor
    import phase_pkg::*;
#(
    parameter int NPHASE  = NPHASE_DEF,
    parameter int MAX_GAP = 4
`ifdef PHASE_MON_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic [NPHASE-1:0]                 phase_en_i,
    input  logic                              err_clr_i,
    output logic [idx_width(NPHASE)-1:0]      phase_idx_o,
    output logic                              phase_valid_o,
    output logic                              cycle_done_o,
    output logic                              locked_o,
    output logic                              err_multi_o,
    output logic                              err_order_o,
    output logic                              err_timeout_o
`ifdef PHASE_MON_CNT_EN
    ,
    output logic [CNT_W-1:0]                  instr_count_o
`endif
);

    localparam int IW = idx_width(NPHASE);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [IW-1:0] LAST = IW'(NPHASE - 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(MAX_GAP);

    function automatic logic [IW-1:0] next_phase(input logic [IW-1:0] k);
        return (k == LAST) ? '0 : k + 1'b1;
    endfunction

    phase_class_t     cls;
    logic [IW-1:0]    k;

    phase_mon_state_t state_q, state_d;
    logic [IW-1:0]    expect_q, expect_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             err_multi_q, err_order_q, err_timeout_q;
    logic             set_multi, set_order, set_timeout;

    phase_onehot_dec #(
        .NPHASE (NPHASE),
        .IW     (IW)
    ) u_dec (
        .phase_en_i (phase_en_i),
        .cls_o      (cls),
        .idx_o      (k)
    );

    // Next-state, per-sample outputs and error events from the classified sample
    always_comb begin
        state_d     = state_q;
        expect_d    = expect_q;
        gap_d       = gap_q;
        idx_d       = idx_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        set_multi   = 1'b0;
        set_order   = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            HUNT: begin
                if (cls == PH_MULTI) begin
                    set_multi = 1'b1;
                end else if (cls == PH_ONE && k == '0) begin
                    state_d  = LOCKED;
                    expect_d = next_phase('0);
                    gap_d    = '0;
                    idx_d    = '0;
                    valid_d  = 1'b1;
                end
            end
            default: begin
                if (cls == PH_MULTI) begin
                    set_multi = 1'b1;
                    state_d   = HUNT;
                    expect_d  = '0;
                    gap_d     = '0;
                end else if (cls == PH_ONE && k == expect_q) begin
                    valid_d  = 1'b1;
                    idx_d    = k;
                    gap_d    = '0;
                    expect_d = next_phase(k);
                    done_d   = (k == LAST);
                end else if (cls == PH_ONE) begin
                    // Out-of-order phase 0 is a fresh cycle start: relock without hunting
                    set_order = 1'b1;
                    gap_d     = '0;
                    if (k == '0) begin
                        expect_d = next_phase('0);
                        idx_d    = '0;
                        valid_d  = 1'b1;
                    end else begin
                        state_d  = HUNT;
                        expect_d = '0;
                    end
                end else if (gap_q == GAP_LIMIT) begin
                    set_timeout = 1'b1;
                    state_d     = HUNT;
                    expect_d    = '0;
                    gap_d       = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase
    end

    // State, tracking registers and sticky errors (a new error beats a clear)
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= HUNT;
            expect_q      <= '0;
            gap_q         <= '0;
            idx_q         <= '0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            err_multi_q   <= 1'b0;
            err_order_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            expect_q      <= expect_d;
            gap_q         <= gap_d;
            idx_q         <= idx_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            err_multi_q   <= set_multi | (err_multi_q & ~err_clr_i);
            err_order_q   <= set_order | (err_order_q & ~err_clr_i);
            err_timeout_q <= set_timeout | (err_timeout_q & ~err_clr_i);
        end
    end

    assign phase_idx_o   = idx_q;
    assign phase_valid_o = valid_q;
    assign cycle_done_o  = done_q;
    assign locked_o      = (state_q == LOCKED);
    assign err_multi_o   = err_multi_q;
    assign err_order_o   = err_order_q;
    assign err_timeout_o = err_timeout_q;

`ifdef PHASE_MON_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Completed instruction cycles, advanced alongside the cycle_done pulse
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (done_d) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign instr_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_phase_monitor.sv
// tb_phase_monitor: directed table, async-reset sequence and randomized model check
module tb_phase_monitor;

    localparam int NP  = 5;
    localparam int GAP = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] phase_en = '0;
    logic       err_clr = 1'b0;
    logic [2:0] phase_idx;
    logic       phase_valid, cycle_done, locked, err_multi, err_order, err_timeout;
`ifdef PHASE_MON_CNT_EN
    logic [15:0] instr_count;
`endif

    phase_monitor #(.NPHASE(NP), .MAX_GAP(GAP)) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .phase_en_i    (phase_en),
        .err_clr_i     (err_clr),
        .phase_idx_o   (phase_idx),
        .phase_valid_o (phase_valid),
        .cycle_done_o  (cycle_done),
        .locked_o      (locked),
        .err_multi_o   (err_multi),
        .err_order_o   (err_order),
        .err_timeout_o (err_timeout)
`ifdef PHASE_MON_CNT_EN
        ,
        .instr_count_o (instr_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] en;
        logic       clr;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural reference: plain integers, follows the protocol rules directly
    bit m_lock, m_val, m_done, m_em, m_eo, m_et;
    int m_exp, m_gap, m_idx, m_cnt;

    function automatic void model_reset();
        m_lock = 0; m_val = 0; m_done = 0; m_em = 0; m_eo = 0; m_et = 0;
        m_exp = 0; m_gap = 0; m_idx = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input logic [4:0] en, input logic clr);
        int n, k;
        n = $countones(en);
        k = 0;
        for (int i = 0; i < NP; i++) if (en[i]) k = i;
        m_val = 0;
        m_done = 0;
        if (clr) begin m_em = 0; m_eo = 0; m_et = 0; end
        if (n > 1) begin
            m_em = 1; m_lock = 0; m_gap = 0;
        end else if (n == 1) begin
            if (!m_lock) begin
                if (k == 0) begin m_lock = 1; m_val = 1; m_idx = 0; m_exp = 1; m_gap = 0; end
            end else if (k == m_exp) begin
                m_val = 1; m_idx = k; m_gap = 0; m_done = (k == NP - 1); m_exp = (k + 1) % NP;
            end else begin
                m_eo = 1; m_gap = 0;
                if (k == 0) begin m_val = 1; m_idx = 0; m_exp = 1; end
                else m_lock = 0;
            end
        end else if (m_lock) begin
            if (m_gap == GAP) begin m_et = 1; m_lock = 0; m_gap = 0; end
            else m_gap++;
        end
        if (m_done) m_cnt = (m_cnt + 1) % 65536;
    endfunction

    function automatic logic [8:0] model_out();
        logic [2:0] ix;
        ix = 3'(m_idx);
        return {ix, m_val, m_done, m_lock, m_em, m_eo, m_et};
    endfunction

    function automatic logic [8:0] dut_out();
        return {phase_idx, phase_valid, cycle_done, locked, err_multi, err_order, err_timeout};
    endfunction

    function automatic void add(input logic [4:0] en, input logic clr, input int idx,
                                input bit val, input bit done, input bit lk,
                                input bit em, input bit eo, input bit et);
        vec_t v;
        logic [2:0] ix;
        ix = 3'(idx);
        v.en = en;
        v.clr = clr;
        v.exp = {ix, val, done, lk, em, eo, et};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [8:0] want);
        logic [8:0] got;
        got = dut_out();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got idx/val/done/lock/em/eo/et=%b want=%b", name, got, want);
        end
    endtask

`ifdef PHASE_MON_CNT_EN
    task automatic check_cnt(input string name);
        vectors++;
        if (instr_count !== 16'(m_cnt)) begin
            miscompares++;
            $display("FAIL %s: instr_count got=%0d want=%0d", name, instr_count, m_cnt);
        end
    endtask
`endif

    task automatic apply(input logic [4:0] en, input logic clr);
        @(negedge clock);
        phase_en = en;
        err_clr = clr;
        @(posedge clock);
        #1;
        model_step(en, clr);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        phase_en = '0;
        err_clr = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0] e;
        int nxt;
        // 1: two clean instruction cycles
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add(5'(1) << p, 0, p, 1, p == NP - 1, 1, 0, 0, 0);
        // 2: out-of-order phase drops lock, phase 0 relocks, clear order error
        add(5'b00001, 0, 0, 1, 0, 1, 0, 0, 0);
        add(5'b00010, 0, 1, 1, 0, 1, 0, 0, 0);
        add(5'b01000, 0, 1, 0, 0, 0, 0, 1, 0);
        add(5'b00001, 0, 0, 1, 0, 1, 0, 1, 0);
        add(5'b00010, 1, 1, 1, 0, 1, 0, 0, 0);
        // 3: multi-hot, set beats clear, then clear alone
        add(5'b00110, 0, 1, 0, 0, 0, 1, 0, 0);
        add(5'b00110, 1, 1, 0, 0, 0, 1, 0, 0);
        add(5'b00000, 1, 1, 0, 0, 0, 0, 0, 0);
        // 4: exactly MAX_GAP zeros tolerated, one more times out
        add(5'b00001, 0, 0, 1, 0, 1, 0, 0, 0);
        add(5'b00010, 0, 1, 1, 0, 1, 0, 0, 0);
        add(5'b00100, 0, 2, 1, 0, 1, 0, 0, 0);
        for (int z = 0; z < GAP; z++) add(5'b00000, 0, 2, 0, 0, 1, 0, 0, 0);
        add(5'b01000, 0, 3, 1, 0, 1, 0, 0, 0);
        add(5'b10000, 0, 4, 1, 1, 1, 0, 0, 0);
        add(5'b00001, 0, 0, 1, 0, 1, 0, 0, 0);
        add(5'b00010, 0, 1, 1, 0, 1, 0, 0, 0);
        add(5'b00100, 0, 2, 1, 0, 1, 0, 0, 0);
        for (int z = 0; z < GAP; z++) add(5'b00000, 0, 2, 0, 0, 1, 0, 0, 0);
        add(5'b00000, 0, 2, 0, 0, 0, 0, 0, 1);
        add(5'b00000, 1, 2, 0, 0, 0, 0, 0, 0);
        // 5: non-zero phases never lock from HUNT
        add(5'b00100, 0, 2, 0, 0, 0, 0, 0, 0);
        add(5'b01000, 0, 2, 0, 0, 0, 0, 0, 0);
        add(5'b10000, 0, 2, 0, 0, 0, 0, 0, 0);
        add(5'b00001, 0, 0, 1, 0, 1, 0, 0, 0);
        // relock in place: phase 0 when phase 1 expected
        add(5'b00001, 0, 0, 1, 0, 1, 0, 1, 0);
        add(5'b00010, 1, 1, 1, 0, 1, 0, 0, 0);

        model_reset();
        #12;
        check("reset_state", 9'b0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].en, tbl[i].clr);
            check($sformatf("table[%0d]", i), tbl[i].exp);
`ifdef PHASE_MON_CNT_EN
            if (i == 2 * NP - 1) check_cnt("count_after_two_cycles");
`endif
        end

        // 6: asynchronous reset between edges clears everything at once
        do_reset();
        apply(5'b00001, 0);
        apply(5'b00010, 0);
        apply(5'b00100, 0);
        check("pre_async_reset", 9'b010_1_0_1_000);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", 9'b0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        apply(5'b01000, 0);
        check("post_reset_phase3_ignored", 9'b000_0_0_0_000);
        apply(5'b00001, 0);
        check("post_reset_lock", 9'b000_1_0_1_000);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            nxt = m_lock ? m_exp : 0;
            case ($urandom_range(0, 9))
                0, 1:    e = '0;
                2:       e = 5'(1) << $urandom_range(0, NP - 1);
                3:       e = 5'($urandom);
                default: e = 5'(1) << nxt;
            endcase
            apply(e, $urandom_range(0, 19) == 0);
            check($sformatf("random[%0d]", i), model_out());
        end
`ifdef PHASE_MON_CNT_EN
        check_cnt("count_after_random");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
